// File: rtl/btn_tx_pkg.sv
// btn_tx_pkg: shared FSM states and ASCII constants for button_tx_scheduler
package btn_tx_pkg;
   // SEND_x/WAIT_x pairs are kept adjacent so each SEND state steps to its WAIT state by +1
   typedef enum logic [2:0] {
      S_IDLE, S_SEND_ID, S_WAIT_ID, S_SEND_CNT, S_WAIT_CNT, S_SEND_NL, S_WAIT_NL
   } state_t;
   localparam logic [7:0] ID_BASE = 8'h41;
   localparam logic [7:0] NL = 8'h0A;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] gnt,
   output logic          vld
);
   int idx;
   // walk from the far end so the candidate closest to ptr is assigned last and wins
   always_comb begin
      gnt = '0;
      vld = 1'b0;
      idx = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            gnt = PW'(idx);
            vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/button_tx_scheduler.sv
// button_tx_scheduler: round-robin sharing of one uart_tx between N_BTN buttons (ID byte + press count).
// Define BTN_TX_NEWLINE_EN to append an 8'h0A byte to every frame.
module button_tx_scheduler
   import btn_tx_pkg::*;
#(
   parameter int N_BTN = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_edge,
   input  logic             tx_busy,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   output logic [N_BTN-1:0] pending,
   output logic             overflow
);
   localparam int PW = N_BTN > 1 ? $clog2(N_BTN) : 1;
`ifdef BTN_TX_NEWLINE_EN
   localparam bit NL_EN = 1'b1;
`else
   localparam bit NL_EN = 1'b0;
`endif
   logic [CNT_W-1:0] cnt_q [N_BTN];
   logic [CNT_W-1:0] cnt_d [N_BTN];
   logic [N_BTN-1:0] pending_q, pending_d;
   logic [PW-1:0]    ptr_q, ptr_d, sel_q, sel_d, gnt;
   logic [7:0]       snap_q, snap_d, tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d, overflow_q, overflow_d, skip_q, skip_d, gnt_vld;
   state_t           state_q, state_d;

   rr_arbiter #(.N(N_BTN), .PW(PW)) u_arb (
      .req(pending_q),
      .ptr(ptr_q),
      .gnt(gnt),
      .vld(gnt_vld)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sel_d      = sel_q;
      snap_d     = snap_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      skip_d     = skip_q;
      pending_d  = pending_q;
      overflow_d = |(btn_edge & pending_q);
      for (int i = 0; i < N_BTN; i++) cnt_d[i] = cnt_q[i] + CNT_W'(btn_edge[i]);
      case (state_q)
         S_IDLE: if (gnt_vld) begin
            state_d        = S_SEND_ID;
            sel_d          = gnt;
            snap_d         = 8'(cnt_q[gnt]);
            ptr_d          = (gnt == PW'(N_BTN - 1)) ? '0 : gnt + PW'(1);
            pending_d[gnt] = 1'b0;
         end
         S_SEND_ID, S_SEND_CNT, S_SEND_NL: if (!tx_busy) begin
            tx_start_d = 1'b1;
            skip_d     = 1'b1;
            tx_data_d  = state_q == S_SEND_ID ? ID_BASE + 8'(sel_q) : state_q == S_SEND_CNT ? snap_q : NL;
            state_d    = state_t'(state_q + 3'd1);
         end
         // first WAIT cycle is ignored: uart_tx only raises busy the cycle after sampling tx_start
         S_WAIT_ID, S_WAIT_CNT, S_WAIT_NL: if (skip_q) skip_d = 1'b0;
         else if (!tx_busy)
            state_d = (state_q == S_WAIT_NL || (state_q == S_WAIT_CNT && !NL_EN)) ? S_IDLE : state_t'(state_q + 3'd1);
         default: state_d = S_IDLE;
      endcase
      pending_d = pending_d | btn_edge;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '{default: '0};
         pending_q  <= '0;
         ptr_q      <= '0;
         sel_q      <= '0;
         snap_q     <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
         skip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         ptr_q      <= ptr_d;
         sel_q      <= sel_d;
         snap_q     <= snap_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         overflow_q <= overflow_d;
         skip_q     <= skip_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_button_tx_scheduler.sv
// tb_button_tx_scheduler: directed scenarios plus randomized presses checked against a per-button press-total model
module tb_button_tx_scheduler;
   localparam int N = 4;
`ifdef BTN_TX_NEWLINE_EN
   localparam int FL = 3;
`else
   localparam int FL = 2;
`endif
   logic         clk = 1'b0, rst = 1'b1;
   logic [N-1:0] btn_edge = '0;
   logic         tx_busy, tx_start, overflow, prev_start;
   logic [7:0]   tx_data;
   logic [N-1:0] pending;
   int           busy_cnt, total, bad;
   bit           busy_hold;
   logic [7:0]   bytes[$];
   logic [7:0]   exp[$];

   always #5 clk = ~clk;
   assign tx_busy = busy_cnt != 0 || busy_hold;

   button_tx_scheduler #(.N_BTN(N), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .btn_edge(btn_edge), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .pending(pending), .overflow(overflow)
   );

   // uart_tx model: busy for 20 cycles starting the cycle after tx_start is sampled
   always @(posedge clk) begin
      if (rst) begin
         busy_cnt   <= 0;
         prev_start <= 1'b0;
      end else begin
         prev_start <= tx_start;
         if (tx_start) begin
            busy_cnt <= 20;
            bytes.push_back(tx_data);
            total++;
            if (prev_start) begin
               bad++;
               $display("FAIL b2b_start tx_start high two cycles running, data=%h", tx_data);
            end
         end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      end
   end

   function automatic void add_frame(input int b, input logic [7:0] c);
      exp.push_back(8'h41 + 8'(b));
      exp.push_back(c);
      if (FL == 3) exp.push_back(8'h0A);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      btn_edge = '0;
      busy_hold = 0;
      cyc(2);
      rst = 1'b0;
      bytes.delete();
      exp.delete();
   endtask

   task automatic press(input logic [N-1:0] m);
      btn_edge = m;
      @(negedge clk);
      btn_edge = '0;
   endtask

   task automatic drain;
      int quiet = 0, n = 0;
      while (quiet < 5 && n < 20000) begin
         @(negedge clk);
         n++;
         quiet = (pending == 0 && !tx_busy && !tx_start) ? quiet + 1 : 0;
      end
      total++;
      if (quiet < 5) begin
         bad++;
         $display("FAIL drain_timeout pending=%b busy=%b", pending, tx_busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      btn_edge = '1;
      cyc(2);
      total++;
      if ({tx_start, tx_data, pending, overflow} !== '0) begin
         bad++;
         $display("FAIL reset_values got start=%b data=%h pend=%b ovf=%b want all zero", tx_start, tx_data, pending, overflow);
      end
      btn_edge = '0;
      rst = 1'b0;
      cyc(4);
      total++;
      if (pending !== '0 || tx_start !== 1'b0) begin
         bad++;
         $display("FAIL reset_quiet got pend=%b start=%b want 0000/0", pending, tx_start);
      end
   endtask

   task automatic test_single;
      do_reset();
      btn_edge = 4'b0001;
      @(negedge clk);
      btn_edge = '0;
      total++;
      if (pending !== 4'b0001 || tx_start !== 1'b0) begin
         bad++;
         $display("FAIL single_t1 got pend=%b start=%b want 0001/0", pending, tx_start);
      end
      @(negedge clk);
      total++;
      if (pending !== 4'b0000 || tx_start !== 1'b0) begin
         bad++;
         $display("FAIL single_grant got pend=%b start=%b want 0000/0", pending, tx_start);
      end
      @(negedge clk);
      total++;
      if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
         bad++;
         $display("FAIL single_latency got start=%b data=%h want 1/41", tx_start, tx_data);
      end
      drain();
      add_frame(0, 8'h01);
      total++;
      if (bytes != exp) begin
         bad++;
         $display("FAIL single_bytes got %p want %p", bytes, exp);
      end
   endtask

   task automatic test_multi;
      do_reset();
      press(4'b1010);
      drain();
      add_frame(1, 8'h01);
      add_frame(3, 8'h01);
      total++;
      if (bytes != exp) begin
         bad++;
         $display("FAIL multi_bytes got %p want %p", bytes, exp);
      end
      bytes.delete();
      exp.delete();
      press(4'b1001);
      drain();
      add_frame(0, 8'h01);
      add_frame(3, 8'h02);
      total++;
      if (bytes != exp) begin
         bad++;
         $display("FAIL multi_ptr_wrap got %p want %p", bytes, exp);
      end
   endtask

   task automatic test_round_robin;
      int nf;
      do_reset();
      btn_edge = '1;
      cyc(300);
      btn_edge = '0;
      drain();
      nf = bytes.size() / FL;
      total++;
      if (nf < 6 || bytes.size() % FL != 0) begin
         bad++;
         $display("FAIL rr_frames got %0d bytes want >= %0d and a multiple of %0d", bytes.size(), 6 * FL, FL);
      end
      for (int k = 0; k < nf; k++) begin
         total++;
         if (bytes[k*FL] !== 8'h41 + 8'(k % N)) begin
            bad++;
            $display("FAIL rr_order frame %0d got id %h want %h", k, bytes[k*FL], 8'h41 + 8'(k % N));
         end
      end
   endtask

   task automatic test_overflow;
      int ov = 0, n = 0;
      do_reset();
      press(4'b0010);
      while (!tx_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) begin
         btn_edge = 4'b0100;
         @(negedge clk);
         ov += int'(overflow);
         btn_edge = '0;
         @(negedge clk);
         ov += int'(overflow);
      end
      total++;
      if (ov != 2 || pending !== 4'b0100) begin
         bad++;
         $display("FAIL ovf_pulses got %0d pulses pend=%b want 2 pulses pend=0100", ov, pending);
      end
      drain();
      add_frame(1, 8'h01);
      add_frame(2, 8'h03);
      total++;
      if (bytes != exp) begin
         bad++;
         $display("FAIL ovf_bytes got %p want %p", bytes, exp);
      end
   endtask

   task automatic test_wrap;
      do_reset();
      busy_hold = 1;
      press(4'b0001);
      cyc(3);
      btn_edge = 4'b1000;
      cyc(256);
      btn_edge = '0;
      total++;
      if (pending !== 4'b1000 || bytes.size() != 0) begin
         bad++;
         $display("FAIL wrap_hold got pend=%b sent=%0d want 1000/0", pending, bytes.size());
      end
      busy_hold = 0;
      drain();
      add_frame(0, 8'h01);
      add_frame(3, 8'h00);
      total++;
      if (bytes != exp) begin
         bad++;
         $display("FAIL wrap_bytes got %p want %p", bytes, exp);
      end
   endtask

   task automatic test_reset_mid;
      int n = 0, starts = 0;
      do_reset();
      press(4'b0001);
      while (bytes.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      cyc(3);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({tx_start, tx_data, pending, overflow} !== '0) begin
         bad++;
         $display("FAIL rstmid_values got start=%b data=%h pend=%b ovf=%b want all zero", tx_start, tx_data, pending, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      bytes.delete();
      repeat (60) begin
         @(negedge clk);
         starts += int'(tx_start);
      end
      total++;
      if (starts != 0 || pending !== '0) begin
         bad++;
         $display("FAIL rstmid_abort got %0d starts pend=%b want 0/0000", starts, pending);
      end
      press(4'b0001);
      drain();
      add_frame(0, 8'h01);
      total++;
      if (bytes != exp) begin
         bad++;
         $display("FAIL rstmid_bytes got %p want %p", bytes, exp);
      end
   endtask

   task automatic test_random;
      int tot[N];
      int last[N];
      logic [N-1:0] m;
      do_reset();
      for (int i = 0; i < N; i++) begin
         tot[i] = 0;
         last[i] = -1;
      end
      repeat (600) begin
         m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         for (int i = 0; i < N; i++) tot[i] += int'(m[i]);
         btn_edge = m;
         @(negedge clk);
      end
      btn_edge = '0;
      drain();
      total++;
      if (bytes.size() % FL != 0) begin
         bad++;
         $display("FAIL rand_len got %0d bytes want a multiple of %0d", bytes.size(), FL);
      end
      for (int k = 0; k + FL <= bytes.size(); k += FL) begin
         total++;
         if (bytes[k] < 8'h41 || bytes[k] > 8'h41 + 8'(N - 1) || (FL == 3 && bytes[k+2] !== 8'h0A)) begin
            bad++;
            $display("FAIL rand_frame at byte %0d got id %h", k, bytes[k]);
         end else last[bytes[k] - 8'h41] = int'(bytes[k+1]);
      end
      for (int i = 0; i < N; i++) begin
         total++;
         if (last[i] != (tot[i] > 0 ? tot[i] % 256 : -1)) begin
            bad++;
            $display("FAIL rand_last_count btn %0d got %0d want %0d", i, last[i], tot[i] > 0 ? tot[i] % 256 : -1);
         end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      busy_hold = 0;
      test_reset();
      test_single();
      test_multi();
      test_round_robin();
      test_overflow();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
